imem_loader: RTL and testbench

- Writer side of the instruction memory that the core fetches from.
- Receives a byte stream over a valid/ready handshake, packs it little-endian into DATA_WIDTH words, and writes them at consecutive word addresses from 0.
- Holds the core in reset (core_hold) from power-up until a load completes, so no instruction is fetched from a half-written image.
- Sits between the host/UART byte source and the write port of the instruction memory.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader_byte_packer.sv | 37 +++
 rtl/imem_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and helpers for the instruction memory loader
package riscv_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  // Bytes packed into one instruction word
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // Width of the byte index inside a word; never narrower than one bit
  function automatic int byte_idx_w(input int data_width);
    return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream input and instruction memory write port
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);

  logic                  s_valid;
  logic [7:0]            s_data;
  logic                  s_ready;
  logic                  iwe;
  logic [ADDR_WIDTH-1:0] iwaddr;
  logic [DATA_WIDTH-1:0] iwdata;

  // Loader side: consumes bytes, drives the memory write port
  modport master (
    input  s_valid, s_data,
    output s_ready, iwe, iwaddr, iwdata
  );

  // Environment side: byte source and instruction memory
  modport slave (
    output s_valid, s_data,
    input  s_ready, iwe, iwaddr, iwdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - inserts bytes little-endian into a word register
module byte_packer
  import riscv_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int BPW = bytes_per_word(DATA_WIDTH),
  localparam int IW  = byte_idx_w(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic [IW-1:0]         i_idx,
  input  logic [7:0]            i_byte,
  output logic [DATA_WIDTH-1:0] o_word
);

  logic [DATA_WIDTH-1:0] r_word;

  // Clear wins over insert; byte k lands in bits [8k+7:8k]
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word <= '0;
    end else if (i_clr) begin
      r_word <= '0;
    end else if (i_we) begin
      for (int k = 0; k < BPW; k++) begin
        if (i_idx == k[IW-1:0]) begin
          r_word[8*k +: 8] <= i_byte;
        end
      end
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a byte stream into instruction memory and holds the core until done
module imem_loader
  import riscv_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [ADDR_WIDTH:0] i_word_count,
  imem_loader_if.master       bus,
  output logic                o_core_hold,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int IW  = byte_idx_w(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [IW-1:0]       LAST_BYTE = IW'(BPW - 1);
  localparam logic [31:0]         TMO_LAST  = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  loader_state_t r_state, w_next;

  // Word index is one bit wider than the address so a full-depth load never wraps
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_widx;
  logic [IW-1:0]         r_bidx;
  logic [31:0]           r_tmo;
  logic                  r_error;
  logic                  r_ok;

  logic                  w_accept;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_timeout;
  logic                  w_start_ok;
  logic                  w_pack_clr;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_accept    = bus.s_valid && (r_state == RECV);
  assign w_last_byte = w_accept && (r_bidx == LAST_BYTE);
  assign w_last_word = (r_widx + 1'b1) == r_count;
  assign w_timeout   = (TIMEOUT != 0) && (r_state == RECV) && !w_accept && (r_tmo == TMO_LAST);
  assign w_start_ok  = (r_state == IDLE) && i_start;
  // Partial words are dropped on error; each written word starts from zero
  assign w_pack_clr  = w_start_ok || (r_state == WRITE) || (r_state == ERR);

  byte_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_pack_clr),
    .i_we  (w_accept),
    .i_idx (r_bidx),
    .i_byte(bus.s_data),
    .o_word(w_word)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state handshake/status outputs
  always_comb begin
    w_next      = r_state;
    bus.s_ready = 1'b0;
    bus.iwe     = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          if (i_word_count == '0) begin
            w_next = DONE;
          end else if (i_word_count > DEPTH) begin
            w_next = ERR;
          end else begin
            w_next = RECV;
          end
        end
      end
      RECV: begin
        bus.s_ready = 1'b1;
        if (w_timeout) begin
          w_next = ERR;
        end else if (w_last_byte) begin
          w_next = WRITE;
        end
      end
      WRITE: begin
        bus.iwe = 1'b1;
        w_next  = w_last_word ? DONE : RECV;
      end
      DONE: begin
        o_done = 1'b1;
        w_next = IDLE;
      end
      ERR: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Counters, latched word count and sticky status flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_widx  <= '0;
      r_bidx  <= '0;
      r_tmo   <= '0;
      r_error <= 1'b0;
      r_ok    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_count <= i_word_count;
            r_widx  <= '0;
            r_bidx  <= '0;
            r_tmo   <= '0;
            r_error <= 1'b0;
            r_ok    <= 1'b0;
          end
        end
        RECV: begin
          if (w_accept) begin
            r_tmo  <= '0;
            r_bidx <= w_last_byte ? '0 : r_bidx + 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        WRITE: begin
          if (!w_last_word) begin
            r_widx <= r_widx + 1'b1;
            r_bidx <= '0;
          end
        end
        DONE: begin
          r_ok <= 1'b1;
        end
        ERR: begin
          r_error <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.iwaddr  = r_widx[ADDR_WIDTH-1:0];
  assign bus.iwdata  = w_word;
  // Core runs only while idle after a successful load
  assign o_core_hold = !((r_state == IDLE) && r_ok);
  assign o_error     = r_error || (r_state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed scoreboard bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] wc;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  imem_loader #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(32),
    .TIMEOUT   (20)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_word_count(wc),
    .bus         (bus),
    .o_core_hold (core_hold),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (error)
  );

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] img[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_iwe  = 0;
  int n_done = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("s_ready_wait", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    if (gap) bus.s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [9:0] a, input logic [31:0] w, input bit gap);
    sb.push_back({a, w});
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], gap);
      if (k == 3) begin
        @(negedge clk);
        chk("iwe_after_last_byte", 64'(bus.iwe), 64'd1);
        chk("iwaddr_in_write", 64'(bus.iwaddr), 64'(a));
        chk("s_ready_in_write", 64'(bus.s_ready), 64'd0);
      end else if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run_load(input int count, input bit gap);
    int  d0;
    bit  seen;
    d0   = n_done;
    seen = 1'b0;
    start = 1'b1;
    wc    = 11'(count);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < count; i++) send_word(10'(i), img[i], gap);
    bus.s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("done_pulses", 64'(n_done - d0), 64'd1);
    chk("core_hold_released", 64'(core_hold), 64'd0);
    chk("error_clear_after_load", 64'(error), 64'd0);
  endtask

  initial begin
    int iwe0;
    int cnt;
    bit seen;

    rst         = 1'b1;
    start       = 1'b0;
    wc          = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
          if (bus.iwe === 1'b1) begin
            wr_t e;
            n_iwe++;
            chk("write_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              chk("sb_iwaddr", 64'(bus.iwaddr), 64'(e.a));
              chk("sb_iwdata", 64'(bus.iwdata), 64'(e.d));
            end
          end
          if (done === 1'b1) n_done++;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_after_reset", 64'({core_hold, bus.iwe, bus.s_ready, done, busy, error}), 64'b100000);
    end

    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'h0010_0093);
    run_load(2, 1'b0);

    @(posedge clk);
    #1;
    iwe0 = n_iwe;
    run_load(2, 1'b1);
    chk("toggle_write_count", 64'(n_iwe - iwe0), 64'd2);

    iwe0 = n_iwe;
    start = 1'b1;
    wc    = 11'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    cnt  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (error === 1'b1) begin
        cnt  = i;
        seen = 1'b1;
        break;
      end
    end
    chk("timeout_seen", 64'(seen), 64'd1);
    chk("timeout_cycles", 64'(cnt), 64'd21);
    repeat (5) @(posedge clk);
    #1;
    chk("timeout_error_sticky", 64'(error), 64'd1);
    chk("timeout_core_hold", 64'(core_hold), 64'd1);
    chk("timeout_not_busy", 64'(busy), 64'd0);
    chk("timeout_no_iwe", 64'(n_iwe - iwe0), 64'd0);

    img.delete();
    img.push_back(32'hDEAD_BEEF);
    run_load(1, 1'b0);

    iwe0 = n_iwe;
    start = 1'b1;
    wc    = 11'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("wc0_done", 64'(done), 64'd1);
    chk("wc0_iwe", 64'(bus.iwe), 64'd0);
    @(negedge clk);
    chk("wc0_done_one_cycle", 64'(done), 64'd0);
    chk("wc0_core_hold", 64'(core_hold), 64'd0);
    chk("wc0_no_writes", 64'(n_iwe - iwe0), 64'd0);

    start = 1'b1;
    wc    = 11'd1025;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("wc1025_error", 64'(error), 64'd1);
    chk("wc1025_no_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("wc1025_error_sticky", 64'(error), 64'd1);
    chk("wc1025_core_hold", 64'(core_hold), 64'd1);
    chk("wc1025_no_writes", 64'(n_iwe - iwe0), 64'd0);
    @(posedge clk);
    #1;

    img.delete();
    for (int i = 0; i < 1024; i++) img.push_back($urandom());
    iwe0 = n_iwe;
    run_load(1024, 1'b0);
    chk("full_depth_writes", 64'(n_iwe - iwe0), 64'd1024);

    start = 1'b1;
    wc    = 11'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) send_word(10'(i), img[i], 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_core_hold", 64'(core_hold), 64'd1);
    chk("rst_iwe", 64'(bus.iwe), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_iwaddr", 64'(bus.iwaddr), 64'd0);
    chk("rst_iwdata", 64'(bus.iwdata), 64'd0);
    chk("rst_sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    img.delete();
    img.push_back(32'h1234_5678);
    img.push_back(32'h9ABC_DEF0);
    run_load(2, 1'b0);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
